// File: rtl/sdram_arb4.sv
//==============================================================================
// Module      : sdram_arb4
// Description : Four-port SDRAM request arbiter with starvation promotion and
//               in-order read-owner tracking for ack routing.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sdram_arb4 #(
    parameter int STARVE_LIMIT = 64,
    parameter int RD_DEPTH     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  p_addr,
    input  logic [127:0]  p_wdata,
    input  logic [15:0]   p_wr,
    input  logic [3:0]    p_rd,
    output logic [3:0]    p_accept,
    output logic [3:0]    p_ack,
    output logic [31:0]   p_rdata,
    output logic [31:0]   c_addr,
    output logic [31:0]   c_wdata,
    output logic [3:0]    c_wr,
    output logic          c_rd,
    input  logic          c_accept,
    input  logic          c_ack,
    input  logic [31:0]   c_rdata,
    output logic          orphan_ack
);

    localparam int              c_PW         = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam logic [0:0]      c_ST_IDLE    = 1'b0;
    localparam logic [0:0]      c_ST_GRANT   = 1'b1;
    localparam logic [7:0]      c_LIMIT      = 8'(STARVE_LIMIT);
    localparam logic [7:0]      c_CNT_ONE    = 8'd1;
    localparam logic [c_PW-1:0] c_PTR_ONE    = 1;
    localparam logic [c_PW:0]   c_FIFO_ONE   = 1;
    localparam logic [c_PW:0]   c_FIFO_FULL  = RD_DEPTH;

    logic [0:0]      r_state, w_state_nxt;
    logic [1:0]      r_grant, w_grant_nxt;
    logic [1:0]      r_rr, w_rr_nxt;
    logic [1:0]      r_fifo [RD_DEPTH];
    logic [c_PW-1:0] r_wptr, r_rptr;
    logic [c_PW:0]   r_count;

    logic [3:0] w_req, w_elig, w_starving;
    logic [2:0] w_sel_starve, w_sel_rr;
    logic       w_pick_vld;
    logic [1:0] w_pick;
    logic       w_full, w_push, w_pop;

    // Returns {found, port}; scans ports 1..3 starting at 'start', wrapping 3 -> 1.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] p;
        rr_pick = 3'b000;
        p = start;
        for (int k = 0; k < 3; k++) begin
            if (!rr_pick[2] && mask[p]) rr_pick = {1'b1, p};
            p = (p == 2'd3) ? 2'd1 : p + 2'd1;
        end
    endfunction

    assign w_full = (r_count == c_FIFO_FULL);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_req[i]  = p_rd[i] | (|p_wr[4*i +: 4]);
            w_elig[i] = w_req[i] & ~(p_rd[i] & w_full);
        end
    end

    assign w_starving[0] = 1'b0;

    for (genvar j = 1; j < 4; j++) begin : g_starve
        logic [7:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (!w_req[j] || p_accept[j]) begin
                r_cnt <= '0;
            end else if (r_cnt != c_LIMIT) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
        assign w_starving[j] = (r_cnt == c_LIMIT);
    end

    always_comb begin
        w_sel_starve = rr_pick(w_elig & w_starving, r_rr);
        w_sel_rr     = rr_pick(w_elig & 4'b1110, r_rr);
        w_pick_vld   = 1'b1;
        w_pick       = 2'd0;
        if (w_sel_starve[2]) begin
            w_pick = w_sel_starve[1:0];
        end else if (w_elig[0]) begin
            w_pick = 2'd0;
        end else if (w_sel_rr[2]) begin
            w_pick = w_sel_rr[1:0];
        end else begin
            w_pick_vld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_grant <= 2'd0;
            r_rr    <= 2'd1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // Outputs are forced quiet while rst is high, even if the state is still GRANT.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr;
        p_accept    = 4'b0000;
        c_addr      = '0;
        c_wdata     = '0;
        c_wr        = 4'b0000;
        c_rd        = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (w_pick_vld) begin
                w_state_nxt = c_ST_GRANT;
                w_grant_nxt = w_pick;
                if (w_pick != 2'd0) w_rr_nxt = (w_pick == 2'd3) ? 2'd1 : w_pick + 2'd1;
            end
        end else if (!rst) begin
            c_addr  = p_addr[{r_grant, 5'b00000} +: 32];
            c_wdata = p_wdata[{r_grant, 5'b00000} +: 32];
            c_wr    = p_wr[{r_grant, 2'b00} +: 4];
            c_rd    = p_rd[r_grant];
            if (c_accept) begin
                p_accept[r_grant] = 1'b1;
                w_state_nxt       = c_ST_IDLE;
            end
        end
    end

    assign w_push  = (|p_accept) & c_rd;
    assign w_pop   = c_ack & ~rst & (r_count != '0);
    assign p_ack   = w_pop ? (4'b0001 << r_fifo[r_rptr]) : 4'b0000;
    assign p_rdata = c_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            orphan_ack <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= r_grant;
                r_wptr         <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) r_rptr <= r_rptr + c_PTR_ONE;
            if (w_push && !w_pop) begin
                r_count <= r_count + c_FIFO_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_FIFO_ONE;
            end
            if (c_ack && (r_count == '0)) orphan_ack <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdram_arb4.sv
//==============================================================================
// Module      : tb_sdram_arb4
// Description : Directed self-checking bench for sdram_arb4 (STARVE_LIMIT=8,
//               RD_DEPTH=2) with a cycle-stepped port and core model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sdram_arb4;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  p_addr, p_wdata;
    logic [15:0]   p_wr;
    logic [3:0]    p_rd;
    logic [3:0]    p_accept, p_ack;
    logic [31:0]   p_rdata, c_addr, c_wdata, c_rdata;
    logic [3:0]    c_wr;
    logic          c_rd, c_accept, c_ack, orphan_ack;

    always #5 clk = ~clk;

    sdram_arb4 #(.STARVE_LIMIT(8), .RD_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_wr(p_wr), .p_rd(p_rd),
        .p_accept(p_accept), .p_ack(p_ack), .p_rdata(p_rdata),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_wr(c_wr), .c_rd(c_rd),
        .c_accept(c_accept), .c_ack(c_ack), .c_rdata(c_rdata),
        .orphan_ack(orphan_ack)
    );

    typedef struct {
        int          port;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic [3:0]  wr;
    } acc_t;

    typedef struct {
        int          port;
        logic [31:0] data;
    } ack_t;

    acc_t       acc_q[$];
    ack_t       ack_q[$];
    int         ack_due[$];
    int         n_vec = 0;
    int         n_miss = 0;
    int         cyc = 0;
    int         base = 0;
    int         ack_n = 0;
    logic [3:0] want_wr, want_rd, acc_mask;
    int         left[4];
    int         seq[4];
    bit         auto_ack;

    function automatic logic [31:0] req_addr(input int port, input int s);
        return {8'hA0 + 8'(port), 8'h00, 16'(s)};
    endfunction

    function automatic int acc_port(input int k);
        return (k < acc_q.size()) ? acc_q[k].port : -1;
    endfunction

    function automatic int acc_cyc(input int k);
        return (k < acc_q.size()) ? acc_q[k].cyc : -1;
    endfunction

    function automatic int ack_port(input int k);
        return (k < ack_q.size()) ? ack_q[k].port : -1;
    endfunction

    function automatic logic [31:0] ack_data(input int k);
        return (k < ack_q.size()) ? ack_q[k].data : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            p_addr[32*i +: 32]  = (want_wr[i] | want_rd[i]) ? req_addr(i, seq[i]) : 32'h0;
            p_wdata[32*i +: 32] = want_wr[i] ? ~req_addr(i, seq[i]) : 32'h0;
            p_wr[4*i +: 4]      = want_wr[i] ? 4'hF : 4'h0;
            p_rd[i]             = want_rd[i];
        end
    endtask

    // Sample mid-cycle, then advance the port/core models just after the edge.
    task automatic step();
        @(negedge clk);
        acc_mask = p_accept;
        for (int i = 0; i < 4; i++) begin
            if (p_accept[i]) begin
                acc_q.push_back(acc_t'{i, cyc - base, c_addr, c_wdata, c_rd, c_wr});
                if (c_rd && auto_ack) ack_due.push_back(cyc + 4);
            end
            if (p_ack[i]) ack_q.push_back(ack_t'{i, p_rdata});
        end
        if (c_ack && ack_due.size() > 0) void'(ack_due.pop_front());
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (acc_mask[i]) begin
                seq[i]++;
                left[i]--;
                if (left[i] <= 0) begin
                    want_wr[i] = 1'b0;
                    want_rd[i] = 1'b0;
                end
            end
        end
        c_ack = (ack_due.size() > 0) && (ack_due[0] == cyc);
        if (c_ack) begin
            ack_n++;
            c_rdata = 32'hA5A5_0000 + 32'(ack_n);
        end else begin
            c_rdata = 32'h0;
        end
        drive();
    endtask

    task automatic start();
        acc_q.delete();
        ack_q.delete();
        base  = cyc;
        ack_n = 0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        want_wr  = 4'b0000;
        want_rd  = 4'b0000;
        c_ack    = 1'b0;
        c_rdata  = 32'h0;
        c_accept = 1'b1;
        auto_ack = 1'b1;
        ack_due.delete();
        for (int i = 0; i < 4; i++) begin
            left[i] = 0;
            seq[i]  = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        rst = 1'b0;
    endtask

    initial begin
        int exp_port[6];
        int exp_cyc[6];

        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        #1;
        check("reset_orphan", {31'b0, orphan_ack}, 32'h0);
        check("reset_c_wr", {28'b0, c_wr}, 32'h0);

        // Reset while a grant waits on the core: outputs go quiet, request survives.
        start();
        c_accept   = 1'b0;
        want_wr[0] = 1'b1;
        left[0]    = 1;
        drive();
        step();
        step();
        #1;
        check("grant_hold_c_wr", {28'b0, c_wr}, 32'hF);
        check("grant_hold_c_addr", c_addr, req_addr(0, 0));
        check("grant_hold_accept", {28'b0, p_accept}, 32'h0);
        rst      = 1'b1;
        c_accept = 1'b1;
        c_ack    = 1'b1;
        #1;
        check("rst_p_accept", {28'b0, p_accept}, 32'h0);
        check("rst_p_ack", {28'b0, p_ack}, 32'h0);
        check("rst_c_wr", {28'b0, c_wr}, 32'h0);
        check("rst_c_addr", c_addr, 32'h0);
        @(posedge clk);
        #1;
        cyc++;
        rst   = 1'b0;
        c_ack = 1'b0;
        acc_q.delete();
        base = cyc;
        repeat (3) step();
        check("rst_regrant_port", acc_port(0), 0);
        check("rst_regrant_cyc", acc_cyc(0), 1);
        check("rst_ack_no_orphan", {31'b0, orphan_ack}, 32'h0);

        // Port 0 beats port 2; port 2 follows two cycles later.
        do_reset();
        start();
        want_wr  = 4'b0101;
        left[0]  = 1;
        left[2]  = 1;
        drive();
        #1;
        check("idle_c_wr", {28'b0, c_wr}, 32'h0);
        check("idle_c_addr", c_addr, 32'h0);
        repeat (6) step();
        check("prio_count", acc_q.size(), 2);
        check("prio_first_port", acc_port(0), 0);
        check("prio_first_cyc", acc_cyc(0), 1);
        check("prio_second_port", acc_port(1), 2);
        check("prio_second_cyc", acc_cyc(1), 3);
        if (acc_q.size() > 0) begin
            check("prio_c_addr", acc_q[0].addr, req_addr(0, 0));
            check("prio_c_wdata", acc_q[0].wdata, ~req_addr(0, 0));
        end

        // Round robin over ports 1..3 with continuous writes.
        do_reset();
        start();
        want_wr = 4'b1110;
        left[1] = 2;
        left[2] = 2;
        left[3] = 2;
        drive();
        repeat (14) step();
        exp_port = '{1, 2, 3, 1, 2, 3};
        exp_cyc  = '{1, 3, 5, 7, 9, 11};
        check("rr_count", acc_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_port%0d", k), acc_port(k), exp_port[k]);
            check($sformatf("rr_cyc%0d", k), acc_cyc(k), exp_cyc[k]);
        end

        // Port 3 starves behind port 0 and is promoted once its counter hits 8.
        do_reset();
        start();
        want_wr = 4'b1001;
        left[0] = 5;
        left[3] = 1;
        drive();
        repeat (14) step();
        exp_port = '{0, 0, 0, 0, 3, 0};
        exp_cyc  = '{1, 3, 5, 7, 9, 11};
        check("starve_count", acc_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("starve_port%0d", k), acc_port(k), exp_port[k]);
            check($sformatf("starve_cyc%0d", k), acc_cyc(k), exp_cyc[k]);
        end

        // Interleaved reads from ports 1 and 2; acks routed in issue order.
        do_reset();
        start();
        want_rd = 4'b0110;
        left[1] = 2;
        left[2] = 2;
        drive();
        repeat (18) step();
        exp_port[0:3] = '{1, 2, 1, 2};
        check("rd_ack_count", ack_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rd_ack_port%0d", k), ack_port(k), exp_port[k]);
            check($sformatf("rd_ack_data%0d", k), ack_data(k), 32'hA5A5_0000 + 32'(k + 1));
        end

        // Full read FIFO blocks the third read; a write slips through meanwhile.
        do_reset();
        start();
        auto_ack   = 1'b0;
        want_rd[1] = 1'b1;
        left[1]    = 3;
        drive();
        repeat (6) step();
        want_wr[2] = 1'b1;
        left[2]    = 1;
        ack_due.push_back(base + 10);
        drive();
        repeat (10) step();
        exp_port[0:3] = '{1, 1, 2, 1};
        exp_cyc[0:3]  = '{1, 3, 7, 12};
        check("full_count", acc_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("full_port%0d", k), acc_port(k), exp_port[k]);
            check($sformatf("full_cyc%0d", k), acc_cyc(k), exp_cyc[k]);
        end
        if (acc_q.size() > 2) check("full_write_wr", {28'b0, acc_q[2].wr}, 32'hF);
        check("full_ack_count", ack_q.size(), 1);
        check("full_ack_port", ack_port(0), 1);

        // Reset drops outstanding read owners; later acks are orphans.
        do_reset();
        start();
        auto_ack   = 1'b0;
        want_rd[1] = 1'b1;
        left[1]    = 2;
        drive();
        repeat (5) step();
        check("orph_pre_accepts", acc_q.size(), 2);
        do_reset();
        start();
        ack_due.push_back(cyc + 2);
        ack_due.push_back(cyc + 4);
        drive();
        step();
        step();
        #1;
        check("orph_before_ack", {31'b0, orphan_ack}, 32'h0);
        step();
        #1;
        check("orph_after_ack1", {31'b0, orphan_ack}, 32'h1);
        repeat (3) step();
        #1;
        check("orph_after_ack2", {31'b0, orphan_ack}, 32'h1);
        check("orph_no_p_ack", ack_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sdram_arb4.md
SDRAM_ARB4 -- requirements
Module: sdram_arb4

Interface
REQ-001 Parameter: STARVE_LIMIT, 64, wait cycles before a low-priority port is promoted (range 2..255).
REQ-002 Parameter: RD_DEPTH, 4, max outstanding reads tracked (power of 2, 2..8).
REQ-003 clk  in  1  single clock; every register is updated on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 p_addr  in  4x32  per-port byte address; port i occupies bits [32i+31:32i].
REQ-006 p_wdata  in  4x32  per-port write data.
REQ-007 p_wr  in  4x4  per-port byte write enables; any bit set means a write request.
REQ-008 p_rd  in  4  per-port read request.
REQ-009 p_accept  out  4  per-port one-cycle accept pulse.
REQ-010 p_ack  out  4  per-port one-cycle read-data-valid pulse.
REQ-011 p_rdata  out  32  read data, broadcast to all ports.
REQ-012 c_addr / c_wdata / c_wr / c_rd  out  32/32/4/1  request to the sdram core.
REQ-013 c_accept  in  1  core has taken the current request.
REQ-014 c_ack  in  1  core read data valid; reads complete in issue order.
REQ-015 c_rdata  in  32  core read data.
REQ-016 orphan_ack  out  1  sticky flag: c_ack was seen with no read outstanding.

Function
REQ-017 A port is requesting when p_rd=1 or p_wr!=0. It holds addr, data and op stable until its p_accept pulse.
REQ-018 The FSM has two states: IDLE and GRANT.
REQ-019 In IDLE with at least one requester: register grant index g and go to GRANT. Otherwise stay in IDLE.
REQ-020 Grant priority, highest first:
  - a starving port among 1-3, round-robin among the starving ports;
  - port 0;
  - ports 1-3, round-robin.
REQ-021 Round-robin pointer: after port k (1-3) is granted, the search starts at the next port in 1-3 order, wrapping 3 to 1; the reset value starts the search at port 1.
REQ-022 In GRANT, c_* carries port g's request unmodified. In IDLE, c_rd=0, c_wr=0, and c_addr/c_wdata=0.
REQ-023 In GRANT with c_accept=1: p_accept[g]=1 in the same cycle (combinational), and the next state is IDLE. Back-to-back grants are therefore separated by one idle cycle; minimum request-to-core latency is 1 cycle.
REQ-024 The grant is locked until accept; no preemption inside GRANT.
REQ-025 Starvation counter per port 1-3:
  - increments each cycle the port requests and is not accepted;
  - saturates at STARVE_LIMIT;
  - clears on that port's accept or when it stops requesting;
  - the port is starving when its counter equals STARVE_LIMIT.
REQ-026 Read owner FIFO, RD_DEPTH entries of 2-bit port index:
  - push g on an accepted read;
  - pop on c_ack;
  - simultaneous push and pop are both honoured, and the count is unchanged.
REQ-027 A read request is not granted while the FIFO is full. Writes may still be granted.
REQ-028 On c_ack with the FIFO non-empty: p_ack[head]=1 and p_rdata=c_rdata in the same cycle.
REQ-029 On c_ack with the FIFO empty: no p_ack is asserted, and orphan_ack is set until reset.
REQ-030 p_rdata=c_rdata at all times. It is valid only with p_ack.
REQ-031 Writes produce no p_ack.

Reset
REQ-032 While rst=1 at a clock edge, all of the following take their reset values:
  - state=IDLE;
  - round-robin pointer reset per REQ-021;
  - starvation counters=0;
  - FIFO empty;
  - orphan_ack=0.
REQ-033 During reset, p_accept=0 and p_ack=0 regardless of c_accept/c_ack, and all c_* outputs are 0.
REQ-034 Reset in GRANT abandons the grant; the requester keeps holding its request.
REQ-035 Reset with reads in flight discards their owners, so later acks set orphan_ack.

Verification
REQ-036 Port 0 and port 2 write in the same IDLE cycle; core accepts at once -> port 0 accepted first, port 2 two cycles later.
REQ-037 Ports 1, 2 and 3 request continuously with writes; core accepts each grant at once -> grant order 1,2,3,1,2,3, each accept 2 cycles apart.
REQ-038 STARVE_LIMIT=8; port 0 issues a new write every cycle while port 3 requests -> port 3 is granted at the first IDLE after its counter reaches 8.
REQ-039 Ports 1 and 2 each issue 2 reads (order 1,2,1,2); core acks 4 cycles after accept -> p_ack pulses on ports 1,2,1,2 with matching c_rdata, e.g. 0xA5A5_0001.
REQ-040 RD_DEPTH=2; three reads accepted with no ack -> the third read waits until the first c_ack; a write from another port is granted in the meantime.
REQ-041 rst pulsed with 2 reads outstanding, then 2 c_ack pulses -> no p_ack, orphan_ack=1 from the first ack onward.
